pool2_flatten: RTL and testbench

Downstream stage of the second pooling layer. Collects the pooled 7×7 maps of all 4 channels (28 rows of 7 × 16-bit values) into a frame buffer. Once the frame is complete, streams it out one value per cycle, channel-major, over a valid/ready handshake to the fully connected layer. Input is blocked while a frame drains, which throttles the pooling stage.

---
 rtl/pool2_pkg.sv | 23 ++
 rtl/flat_row_ram.sv | 25 ++
 rtl/pool2_flatten.sv | 125 ++++++++++++
 tb/tb_pool2_flatten.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pool2_pkg.sv
// Shared geometry and types for the pool2 flatten stage: 4 channels of
// 7x7 pooled maps, stored as 28 row entries of 7 x 16-bit values.
package pool2_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned COLS   = 7;
  localparam int unsigned ROWS   = 7;
  localparam int unsigned CH     = 4;
  localparam int unsigned ROW_W  = COLS * DW;
  localparam int unsigned N_ROWS = 28;
  localparam int unsigned N_OUT  = 196;
  localparam int unsigned AW     = 5;
  localparam int unsigned IDX_W  = 8;

  typedef enum logic {FILL, DRAIN} state_t;

  // Buffer entries are channel-major, so draining entries 0..27 in order
  // yields the flattened ch*49 + row*7 + col sequence.
  function automatic logic [AW-1:0] entry_of(input logic [1:0] ch, input logic [2:0] row);
    return AW'(ch) * AW'(ROWS) + AW'(row);
  endfunction

endpackage

// File: rtl/flat_row_ram.sv
// Row-wide frame buffer: one write port, one synchronous read port with
// a single cycle of read latency. Contents are deliberately not reset.
module flat_row_ram
  import pool2_pkg::*;
#(
  parameter int unsigned DEPTH  = N_ROWS,
  parameter int unsigned WIDTH  = ROW_W,
  parameter int unsigned ADDR_W = AW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pool2_flatten.sv
// Collects a 28-row pooled frame, then streams it out one value per cycle
// in channel-major flattened order over a valid/ready handshake.
module pool2_flatten
  import pool2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [ROW_W-1:0]  in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              err
);

  state_t             state_q, state_d;
  logic [1:0]         exp_ch;
  logic [2:0]         exp_row;
  logic [AW-1:0]      rd_entry, nx_entry, raddr, wr_addr;
  logic [2:0]         rd_col, nx_col;
  logic [IDX_W-1:0]   ld_cnt;
  logic               rd_primed;
  logic [ROW_W-1:0]   rd_data;
  logic [DW-1:0]      sel_val;
  logic               accept, wr_en, last_row, load, done;

  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && (in_sel == exp_ch);
  assign last_row = (exp_ch == 2'(CH - 1)) && (exp_row == 3'(ROWS - 1));
  assign wr_addr  = entry_of(exp_ch, exp_row);
  assign done     = out_valid && out_ready && out_last;
  // rd_data always holds entry rd_entry, so the pointer moves with each load.
  assign load     = rd_primed && (!out_valid || out_ready) && (ld_cnt != IDX_W'(N_OUT));
  assign raddr    = load ? nx_entry : rd_entry;
  assign sel_val  = rd_data[rd_col*DW +: DW];

  always_comb begin
    nx_col   = rd_col + 3'd1;
    nx_entry = rd_entry;
    if (rd_col == 3'(COLS - 1)) begin
      nx_col   = '0;
      nx_entry = (rd_entry == AW'(N_ROWS - 1)) ? '0 : rd_entry + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (wr_en && last_row) state_d = DRAIN;
      end
      DRAIN: begin
        if (done) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_ch    <= '0;
      exp_row   <= '0;
      err       <= 1'b0;
      rd_entry  <= '0;
      rd_col    <= '0;
      ld_cnt    <= '0;
      rd_primed <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      // First DRAIN cycle only issues the read of entry 0.
      rd_primed <= (state_q == DRAIN) && !done;
      if (accept && (in_sel != exp_ch)) err <= 1'b1;
      if (wr_en) begin
        if (exp_ch == 2'(CH - 1)) begin
          exp_ch  <= '0;
          exp_row <= (exp_row == 3'(ROWS - 1)) ? '0 : exp_row + 3'd1;
        end else begin
          exp_ch <= exp_ch + 2'd1;
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sel_val;
        out_idx   <= ld_cnt;
        out_last  <= (ld_cnt == IDX_W'(N_OUT - 1));
        ld_cnt    <= ld_cnt + IDX_W'(1);
        rd_entry  <= nx_entry;
        rd_col    <= nx_col;
      end else if (done) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_idx   <= '0;
        ld_cnt    <= '0;
      end
    end
  end

  flat_row_ram #(
    .DEPTH (N_ROWS),
    .WIDTH (ROW_W),
    .ADDR_W(AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(in_row),
    .raddr(raddr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_pool2_flatten.sv
// Directed bench for pool2_flatten: nominal, backpressure, wrong channel,
// input blocking, mid-drain reset and inverted back-to-back frames.
module tb_pool2_flatten;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [111:0] in_row;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [7:0]   out_idx;
  logic         out_last;
  logic         err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pool2_flatten dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fv(input int idx, input bit inv);
    logic [15:0] v;
    v = 16'(idx);
    return inv ? (16'hFFFF - v) : v;
  endfunction

  task automatic send_row(input int ch, input int row, input int sel, input bit inv);
    int budget = 50;
    in_valid = 1'b1;
    in_sel   = 2'(sel);
    for (int c = 0; c < 7; c++) in_row[c*16 +: 16] = fv(ch*49 + row*7 + c, inv);
    while (!in_ready && budget > 0) begin
      budget--;
      step();
    end
    if (budget == 0) check("row_accept_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Fills a frame; with bad set, a ch2 row is offered where ch1 row 0 is due.
  task automatic send_frame(input bit inv, input bit bad);
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (bad && r == 0 && c == 1) begin
          send_row(2, 0, 2, inv);
          check("err_set", 32'(err), 32'd1);
        end
        send_row(c, r, c, inv);
      end
    end
    check("lat_c0_valid", 32'(out_valid), 32'd0);
    check("drain_blocks", 32'(in_ready), 32'd0);
    step();
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    step();
    check("lat_c2_valid", 32'(out_valid), 32'd1);
    check("first_idx", 32'(out_idx), 32'd0);
  endtask

  task automatic drain(input bit inv, input bit rand_ready, input bit hold_in, input int stop_at);
    int          got = 0;
    int          budget = 3000;
    bit          stalled = 1'b0;
    logic [15:0] hd = '0;
    logic [7:0]  hi = '0;
    in_valid = hold_in;
    in_sel   = 2'd0;
    in_row   = {7{16'h5A5A}};
    while (got < stop_at && budget > 0) begin
      budget--;
      if (stalled) begin
        check("stall_data", 32'(out_data), 32'(hd));
        check("stall_idx", 32'(out_idx), 32'(hi));
      end
      check("in_blocked", 32'(in_ready), 32'd0);
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!rand_ready) check("no_gap", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (out_ready) begin
          check("data", 32'(out_data), 32'(fv(got, inv)));
          check("idx", 32'(out_idx), 32'(got));
          check("last", 32'(out_last), (got == 195) ? 32'd1 : 32'd0);
          if (got == 195) in_valid = 1'b0;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = out_data;
          hi = out_idx;
        end
      end
      step();
    end
    check("drain_count", 32'(got), 32'(stop_at));
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (stop_at == 196) begin
      check("turnaround_rdy", 32'(in_ready), 32'd1);
      check("post_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_row    = '0;
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Nominal frame, consumer always ready
    send_frame(1'b0, 1'b0);
    check("err_clear", 32'(err), 32'd0);
    drain(1'b0, 1'b0, 1'b0, 196);

    // Wrong channel then random backpressure
    send_frame(1'b0, 1'b1);
    drain(1'b0, 1'b1, 1'b0, 196);

    // Inverted frame back-to-back, input held valid during drain
    send_frame(1'b1, 1'b0);
    check("err_sticky", 32'(err), 32'd1);
    drain(1'b1, 1'b0, 1'b1, 196);

    // Reset in the middle of a drain
    send_frame(1'b0, 1'b0);
    drain(1'b0, 1'b0, 1'b0, 100);
    check("mid_idx", 32'(out_idx), 32'd100);
    rst = 1'b0;
    step();
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_idx", 32'(out_idx), 32'd0);
    rst = 1'b1;

    // Fresh inverted frame after the abandoned drain
    send_frame(1'b1, 1'b0);
    drain(1'b1, 1'b0, 1'b0, 196);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
